// File: rtl/spi_seq_pkg.sv
// Shared constants and FSM state encodings for the SPI transaction scheduler.
package spi_seq_pkg;

   localparam int SPI_XFER_CYC = 42;
   localparam int PER_MIN      = 48;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_ISSUE_CFG = 3'd1;
   localparam state_t S_ISSUE_DAC = 3'd2;
   localparam state_t S_WAIT      = 3'd3;
   localparam state_t S_GAP       = 3'd4;

endpackage

// File: rtl/spi_seq_sched_if.sv
// Scheduler bus: run control, FIFO status and engine handshake in, triggers and status flags out.
interface spi_seq_sched_if #(
   parameter int PER_W = 16
);

   logic             enable;
   logic [PER_W-1:0] period;
   logic             cfg_empty;
   logic             wav_empty;
   logic             spi_done;
   logic             clr_flags;
   logic             trig_cfg;
   logic             trig_dac;
   logic             busy;
   logic             underrun;
   logic             stall;
   logic [7:0]       drop_cnt;
   logic [PER_W-1:0] tick_count;

   modport master (
      input  enable, period, cfg_empty, wav_empty, spi_done, clr_flags,
      output trig_cfg, trig_dac, busy, underrun, stall, drop_cnt, tick_count
   );

   modport slave (
      output enable, period, cfg_empty, wav_empty, spi_done, clr_flags,
      input  trig_cfg, trig_dac, busy, underrun, stall, drop_cnt, tick_count
   );

endinterface

// File: rtl/spi_seq_sched_tick.sv
// DAC sample-rate tick: counts 0..P-1 with P = max(period, PER_MIN), period captured only at wrap.
module spi_seq_tick
   import spi_seq_pkg::*;
#(
   parameter int PER_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic [PER_W-1:0] i_period,
   output logic             o_tick,
   output logic [PER_W-1:0] o_count
);

   localparam logic [PER_W-1:0] MIN_P = PER_W'(PER_MIN);

   logic [PER_W-1:0] r_count;
   logic [PER_W-1:0] r_per;
   logic [PER_W-1:0] w_perClamped;

   assign w_perClamped = (i_period < MIN_P) ? MIN_P : i_period;
   assign o_tick       = i_enable && (r_count == (r_per - 1'b1));
   assign o_count      = r_count;

   // While disabled the counter parks at 0 and keeps tracking period, so a restart uses the current value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_per   <= MIN_P;
      end else if (!i_enable || o_tick) begin
         r_count <= '0;
         r_per   <= w_perClamped;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_seq_sched.sv
// SPI transaction scheduler: tick-driven DAC requests with strict priority over config words.
// Optional transaction watchdog enabled by defining SPI_SEQ_WDOG_EN.
module spi_seq_sched
   import spi_seq_pkg::*;
#(
   parameter int PER_W    = 16,
   parameter int GAP_CYC  = 2,
   parameter int WDOG_CYC = 64
)(
   input  logic            clk,
   input  logic            rst,
   spi_seq_sched_if.master bus
);

   localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

   state_t           r_state;
   state_t           w_next;
   logic             r_dacPend;
   logic             r_cfgRdy;
   logic             r_trigCfg;
   logic             r_trigDac;
   logic             r_busy;
   logic             r_underrun;
   logic [7:0]       r_dropCnt;
   logic [GAP_W-1:0] r_gapCnt;
   logic             w_tick;
   logic             w_lost;
   logic             w_wdogExp;
   logic [PER_W-1:0] w_tickCount;

   spi_seq_tick #(
      .PER_W(PER_W)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .i_enable (bus.enable),
      .i_period (bus.period),
      .o_tick   (w_tick),
      .o_count  (w_tickCount)
   );

`ifdef SPI_SEQ_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);

   logic [WDOG_W-1:0] r_wdog;
   logic              r_stall;

   assign w_wdogExp = (r_state == S_WAIT) && !bus.spi_done &&
                      (r_wdog == WDOG_W'(WDOG_CYC - 1));

   // r_wdog holds cycles elapsed since the trigger while waiting for the engine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog  <= '0;
         r_stall <= 1'b0;
      end else begin
         if (r_state != S_WAIT)
            r_wdog <= WDOG_W'(1);
         else
            r_wdog <= r_wdog + 1'b1;
         if (w_wdogExp)
            r_stall <= 1'b1;
         else if (bus.clr_flags)
            r_stall <= 1'b0;
      end
   end

   assign bus.stall = r_stall;
`else
   assign w_wdogExp = 1'b0;
   assign bus.stall = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.enable && r_dacPend)
               w_next = S_ISSUE_DAC;
            else if (bus.enable && r_cfgRdy)
               w_next = S_ISSUE_CFG;
         end
         S_ISSUE_CFG, S_ISSUE_DAC: w_next = S_WAIT;
         S_WAIT: begin
            if (bus.spi_done || w_wdogExp)
               w_next = S_GAP;
         end
         S_GAP: begin
            if (r_gapCnt == '0)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_lost = w_tick && (r_dacPend || bus.wav_empty);

   // Triggers and busy are decoded from the next state so they align with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_trigCfg <= 1'b0;
         r_trigDac <= 1'b0;
         r_busy    <= 1'b0;
         r_cfgRdy  <= 1'b0;
         r_dacPend <= 1'b0;
         r_gapCnt  <= '0;
      end else begin
         r_state   <= w_next;
         r_trigCfg <= (w_next == S_ISSUE_CFG);
         r_trigDac <= (w_next == S_ISSUE_DAC);
         r_busy    <= (w_next != S_IDLE);
         r_cfgRdy  <= !bus.cfg_empty;
         if (w_next == S_ISSUE_DAC)
            r_dacPend <= 1'b0;
         if (w_tick && !bus.wav_empty)
            r_dacPend <= 1'b1;
         if (r_state == S_WAIT)
            r_gapCnt <= GAP_W'(GAP_CYC - 1);
         else if (r_gapCnt != '0)
            r_gapCnt <= r_gapCnt - 1'b1;
      end
   end

   // A lost tick beats a simultaneous clear, leaving the count at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun <= 1'b0;
         r_dropCnt  <= '0;
      end else if (w_lost) begin
         r_underrun <= 1'b1;
         if (bus.clr_flags)
            r_dropCnt <= 8'd1;
         else if (r_dropCnt != 8'hFF)
            r_dropCnt <= r_dropCnt + 1'b1;
      end else if (bus.clr_flags) begin
         r_underrun <= 1'b0;
         r_dropCnt  <= '0;
      end
   end

   assign bus.trig_cfg   = r_trigCfg;
   assign bus.trig_dac   = r_trigDac;
   assign bus.busy       = r_busy;
   assign bus.underrun   = r_underrun;
   assign bus.drop_cnt   = r_dropCnt;
   assign bus.tick_count = w_tickCount;

endmodule

// File: tb/tb_spi_seq_sched.sv
// Directed bench for spi_seq_sched with a 42-cycle engine model and a config FIFO word counter.
module tb_spi_seq_sched;
   import spi_seq_pkg::*;

   localparam int PER_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   spi_seq_sched_if #(.PER_W(PER_W)) bus ();

   spi_seq_sched #(
      .PER_W    (PER_W),
      .GAP_CYC  (2),
      .WDOG_CYC (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   total      = 0;
   int   bad        = 0;
   int   cfgLoad    = 0;
   int   cfgPopped  = 0;
   int   trigDacCnt = 0;
   int   engCnt     = 0;
   bit   engOn      = 1'b1;
   logic engDone    = 1'b0;
   logic manDone    = 1'b0;

   assign bus.cfg_empty = (cfgPopped >= cfgLoad);
   assign bus.spi_done  = engDone | manDone;

   // Engine model: answers each trigger with spi_done SPI_XFER_CYC cycles later and pops config words.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         engDone = 1'b0;
         if (rst) begin
            engCnt = 0;
         end else begin
            if (engCnt > 0) begin
               engCnt--;
               if (engCnt == 0) engDone = 1'b1;
            end
            if (bus.trig_dac || bus.trig_cfg) begin
               if (bus.trig_dac) trigDacCnt++;
               if (bus.trig_cfg) cfgPopped++;
               if (engOn) engCnt = SPI_XFER_CYC;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitTrig(input int maxCyc, output int n, output logic isDac);
      bit found = 1'b0;
      n = -1;
      isDac = 1'b0;
      for (int i = 1; i <= maxCyc && !found; i++) begin
         @(negedge clk);
         if (bus.trig_dac || bus.trig_cfg) begin
            found = 1'b1;
            n = i;
            isDac = bus.trig_dac;
         end
      end
   endtask

   task automatic waitDone(input int maxCyc, output int n);
      bit found = 1'b0;
      n = -1;
      for (int i = 1; i <= maxCyc && !found; i++) begin
         @(negedge clk);
         if (bus.spi_done) begin
            found = 1'b1;
            n = i;
         end
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [PER_W-1:0] per, input logic wavE);
      bus.enable    = en;
      bus.period    = per;
      bus.wav_empty = wavE;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_trig_cfg"}, 32'(bus.trig_cfg), 0);
      checkOutput({tag, "_trig_dac"}, 32'(bus.trig_dac), 0);
      checkOutput({tag, "_busy"},     32'(bus.busy), 0);
      checkOutput({tag, "_underrun"}, 32'(bus.underrun), 0);
      checkOutput({tag, "_stall"},    32'(bus.stall), 0);
      checkOutput({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 0);
      checkOutput({tag, "_tick_cnt"}, 32'(bus.tick_count), 0);
   endtask

   initial begin
      int   n;
      logic d;
      int   base;

      bus.clr_flags = 1'b0;
      applyStimulus(1'b0, 16'd100, 1'b0);
      waitCycles(3);
      checkAllZero("reset");
      rst = 1'b0;
      waitCycles(2);

      manDone = 1'b1;
      waitCycles(1);
      manDone = 1'b0;
      waitCycles(2);
      checkOutput("done_in_idle_busy", 32'(bus.busy), 0);

      // DAC stream at period 100, then a period change that takes effect only at the next wrap.
      bus.enable = 1'b1;
      waitTrig(300, n, d);
      checkOutput("dac_first_latency", n, 101);
      checkOutput("dac_first_is_dac", 32'(d), 1);
      waitCycles(1);
      checkOutput("trig_dac_width", 32'(bus.trig_dac), 0);
      checkOutput("busy_in_wait", 32'(bus.busy), 1);
      waitTrig(300, n, d);
      checkOutput("dac_period_100", n, 99);
      bus.period = 16'd10;
      waitTrig(300, n, d);
      checkOutput("dac_period_until_wrap", n, 100);
      waitTrig(300, n, d);
      checkOutput("dac_period_clamped_48", n, 48);
      checkOutput("dac_stream_drop_cnt", 32'(bus.drop_cnt), 0);
      checkOutput("dac_stream_underrun", 32'(bus.underrun), 0);
      bus.enable = 1'b0;
      waitCycles(1);
      checkOutput("disable_mid_xfer_busy", 32'(bus.busy), 1);
      waitTrig(60, n, d);
      checkOutput("disabled_no_trigger", n, -1);
      checkOutput("disabled_idle_busy", 32'(bus.busy), 0);

      // Three config words loaded just before a tick; the tick is served between words.
      bus.period = 16'd200;
      waitCycles(2);
      bus.enable = 1'b1;
      waitCycles(170);
      cfgLoad = cfgLoad + 3;
      waitTrig(10, n, d);
      checkOutput("cfg_latency", n, 2);
      checkOutput("cfg_first_is_cfg", 32'(d), 0);
      waitDone(100, n);
      waitTrig(20, n, d);
      checkOutput("gap_before_dac", n, 4);
      checkOutput("tick_served_before_cfg", 32'(d), 1);
      waitDone(100, n);
      waitTrig(20, n, d);
      checkOutput("gap_before_cfg2", n, 4);
      checkOutput("cfg2_is_cfg", 32'(d), 0);
      waitDone(100, n);
      waitTrig(20, n, d);
      checkOutput("gap_before_cfg3", n, 4);
      checkOutput("cfg3_is_cfg", 32'(d), 0);
      waitDone(100, n);
      waitCycles(10);
      checkOutput("cfg_done_busy", 32'(bus.busy), 0);
      checkOutput("cfg_drop_cnt", 32'(bus.drop_cnt), 0);
      bus.enable = 1'b0;
      waitCycles(2);

      // Waveform FIFO empty: every tick is lost; period 10 clamps to 48.
      base = trigDacCnt;
      applyStimulus(1'b0, 16'd10, 1'b1);
      waitCycles(2);
      bus.enable = 1'b1;
      waitCycles(47);
      checkOutput("clamp_count_top", 32'(bus.tick_count), 47);
      waitCycles(1);
      checkOutput("clamp_count_wrap", 32'(bus.tick_count), 0);
      checkOutput("underrun_first_drop", 32'(bus.drop_cnt), 1);
      waitCycles(144);
      checkOutput("underrun_flag", 32'(bus.underrun), 1);
      checkOutput("underrun_drop_4", 32'(bus.drop_cnt), 4);
      checkOutput("underrun_no_trig_dac", trigDacCnt - base, 0);
      bus.clr_flags = 1'b1;
      waitCycles(1);
      bus.clr_flags = 1'b0;
      checkOutput("clr_underrun", 32'(bus.underrun), 0);
      checkOutput("clr_drop_cnt", 32'(bus.drop_cnt), 0);
      waitCycles(46);
      bus.clr_flags = 1'b1;
      waitCycles(1);
      bus.clr_flags = 1'b0;
      checkOutput("clr_vs_set_drop", 32'(bus.drop_cnt), 1);
      checkOutput("clr_vs_set_underrun", 32'(bus.underrun), 1);
      waitCycles(12240);
      checkOutput("drop_cnt_saturates", 32'(bus.drop_cnt), 255);
      bus.enable = 1'b0;
      bus.clr_flags = 1'b1;
      waitCycles(1);
      bus.clr_flags = 1'b0;
      bus.wav_empty = 1'b0;
      waitCycles(2);
      checkOutput("final_clr_drop", 32'(bus.drop_cnt), 0);

      // Engine never answers.
      engOn = 1'b0;
      bus.period = 16'd48;
      waitCycles(2);
      bus.enable = 1'b1;
      waitTrig(100, n, d);
      checkOutput("stall_trig_latency", n, 49);
`ifdef SPI_SEQ_WDOG_EN
      begin
         bit found = 1'b0;
         n = -1;
         for (int i = 1; i <= 100 && !found; i++) begin
            @(negedge clk);
            if (bus.stall) begin
               found = 1'b1;
               n = i;
            end
         end
      end
      checkOutput("wdog_stall_delay", n, 64);
      waitCycles(2);
      checkOutput("wdog_back_to_idle", 32'(bus.busy), 0);
      waitTrig(10, n, d);
      checkOutput("wdog_pending_dac", n, 1);
      waitCycles(5);
`else
      waitCycles(80);
      checkOutput("no_wdog_still_busy", 32'(bus.busy), 1);
      checkOutput("no_wdog_stall_zero", 32'(bus.stall), 0);
`endif

      // Reset while waiting on the engine.
      rst = 1'b1;
      #1;
      checkAllZero("rst_in_wait");
      waitCycles(1);
      rst = 1'b0;
      engOn = 1'b1;
      waitTrig(100, n, d);
      checkOutput("post_rst_trig_latency", n, 49);
      checkOutput("post_rst_is_dac", 32'(d), 1);
      checkOutput("post_rst_drop_cnt", 32'(bus.drop_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
